ps2_key_decoder: RTL and testbench

- Receives PS/2 keyboard frames and decodes the scancode stream into the 5-bit KEY_PRESSED code consumed by the directions logic.
- Each player has four direction keys, giving codes 0..15. Space gives start code 16. Code 31 means no key is active.
- Sits between the board PS/2 pins and the game mechanics, in the CLOCK_50 domain.

---
 rtl/ps2_key_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scancode decoder for the game's KEY_PRESSED code.
// Frames are sampled on synchronized PS2_CLK falling edges; decode runs one cycle after a good frame.
module ps2_key_decoder #(
  parameter int         TIMEOUT   = 5000,
  parameter logic [4:0] NONE_CODE = 5'd31
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic [7:0] scan_byte,
  output logic       frame_error
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  rx_state_e        state_q, state_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             dat_meta_q, dat_sync_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             byte_done_q, frame_err_q;
  logic [7:0]       scan_byte_q;
  logic             ext_q, brk_q;
  logic [4:0]       key_q;
  logic             key_valid_q;

  logic             fall;
  logic             timeout;
  logic             stop_seen;
  logic             byte_done_d;
  logic             frame_err_d;
  logic             map_hit;
  logic [4:0]       map_code;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  // Synchronizers reset to the idle-high line level so releasing reset cannot fake a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = (state_q != S_IDLE) && !fall && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!dat_sync_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stop_seen   = fall && (state_q == S_STOP);
    byte_done_d = stop_seen && (^{shift_q, parity_q}) && dat_sync_q;
    frame_err_d = timeout || (stop_seen && !byte_done_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      scan_byte_q <= 8'h00;
    end else begin
      if (fall && state_q == S_IDLE) begin
        bit_cnt_q <= 3'd0;
      end else if (fall && state_q == S_DATA) begin
        shift_q   <= {dat_sync_q, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (fall && state_q == S_PARITY) parity_q <= dat_sync_q;
      if (state_q == S_IDLE || fall) tmo_cnt_q <= '0;
      else                           tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
      if (byte_done_d) scan_byte_q <= shift_q;
    end
  end

  // Direction order per player is up, down, left, right.
  always_comb begin
    map_hit  = 1'b1;
    map_code = NONE_CODE;
    case ({ext_q, scan_byte_q})
      {1'b0, 8'h1D}: map_code = 5'd0;
      {1'b0, 8'h1B}: map_code = 5'd1;
      {1'b0, 8'h1C}: map_code = 5'd2;
      {1'b0, 8'h23}: map_code = 5'd3;
      {1'b1, 8'h75}: map_code = 5'd4;
      {1'b1, 8'h72}: map_code = 5'd5;
      {1'b1, 8'h6B}: map_code = 5'd6;
      {1'b1, 8'h74}: map_code = 5'd7;
      {1'b0, 8'h43}: map_code = 5'd8;
      {1'b0, 8'h42}: map_code = 5'd9;
      {1'b0, 8'h3B}: map_code = 5'd10;
      {1'b0, 8'h4B}: map_code = 5'd11;
      {1'b0, 8'h75}: map_code = 5'd12;
      {1'b0, 8'h73}: map_code = 5'd13;
      {1'b0, 8'h6B}: map_code = 5'd14;
      {1'b0, 8'h74}: map_code = 5'd15;
      {1'b0, 8'h29}: map_code = 5'd16;
      default:       map_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= NONE_CODE;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (byte_done_q) begin
        if (scan_byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (scan_byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (map_hit) begin
            if (!brk_q) begin
              key_q       <= map_code;
              key_valid_q <= 1'b1;
            end else if (map_code == key_q) begin
              key_q <= NONE_CODE;
            end
          end
        end
      end
      // A bad or aborted frame breaks any prefix sequence in progress.
      if (frame_err_d) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign KEY_PRESSED = key_q;
  assign key_valid   = key_valid_q;
  assign scan_byte   = scan_byte_q;
  assign frame_error = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: PS/2 frames driven at random bit timing, outputs compared every cycle
// against an event-scheduled behavioural model, plus literal checks from the directed scenarios.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] key_pressed;
  logic       key_valid;
  logic [7:0] scan_byte;
  logic       frame_error;

  ps2_key_decoder dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .PS2_CLK     (ps2_clk),
    .PS2_DAT     (ps2_dat),
    .KEY_PRESSED (key_pressed),
    .key_valid   (key_valid),
    .scan_byte   (scan_byte),
    .frame_error (frame_error)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         due;
    bit         rst;
    bit         set_scan;
    logic [7:0] scan;
    bit         ferr;
    bit         set_key;
    logic [4:0] key;
    bit         kv;
  } ev_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   kv_seen = 0;
  int   tmo_pulses = 0;
  bit   tmo_window = 0;
  ev_t  evq[$];

  // Values the outputs must show on the current cycle.
  logic [4:0] e_key = 5'd31;
  logic [7:0] e_scan = 8'h00;
  logic       e_kv = 1'b0;
  logic       e_ferr = 1'b0;

  // Model state as of the last frame handed to the DUT.
  int         m_key = 31;
  bit         m_ext = 0;
  bit         m_brk = 0;
  int         plain_map [logic [7:0]];
  int         ext_map   [logic [7:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t blank_ev(input int due);
    ev_t e;
    e.due = due; e.rst = 0; e.set_scan = 0; e.scan = 8'h00;
    e.ferr = 0; e.set_key = 0; e.key = 5'd31; e.kv = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    e_kv   = 1'b0;
    e_ferr = 1'b0;
    while (evq.size() > 0 && evq[0].due <= cyc) begin
      ev_t e;
      e = evq.pop_front();
      if (e.rst) begin
        e_key  = 5'd31;
        e_scan = 8'h00;
      end
      if (e.set_scan) e_scan = e.scan;
      if (e.ferr)     e_ferr = 1'b1;
      if (e.set_key) begin
        e_key = e.key;
        e_kv  = e.kv;
      end
    end
    if (cyc >= 1) begin
      check("key_pressed", 32'(key_pressed), 32'(e_key));
      check("key_valid",   32'(key_valid),   32'(e_kv));
      check("scan_byte",   32'(scan_byte),   32'(e_scan));
      if (tmo_window) begin
        if (frame_error) tmo_pulses++;
      end else begin
        check("frame_error", 32'(frame_error), 32'(e_ferr));
      end
      if (key_valid) kv_seen++;
    end
  end

  // Outcome of a complete frame whose stop-bit falling edge was driven at cycle f:
  // scan_byte / frame_error settle 3 cycles later, the decoded key one cycle after that.
  task automatic model_frame(input logic [7:0] b, input bit ok, input int f);
    ev_t e;
    int  code;
    e = blank_ev(f + 3);
    if (!ok) begin
      e.ferr = 1;
      evq.push_back(e);
      m_ext = 0;
      m_brk = 0;
      return;
    end
    e.set_scan = 1;
    e.scan     = b;
    evq.push_back(e);
    if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      code = -1;
      if (m_ext && ext_map.exists(b))   code = ext_map[b];
      if (!m_ext && plain_map.exists(b)) code = plain_map[b];
      if (code >= 0) begin
        e = blank_ev(f + 4);
        if (!m_brk) begin
          m_key = code;
          e.set_key = 1; e.key = 5'(code); e.kv = 1;
          evq.push_back(e);
        end else if (code == m_key) begin
          m_key = 31;
          e.set_key = 1; e.key = 5'd31; e.kv = 0;
          evq.push_back(e);
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    ps2_clk = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [9:0] head;
    logic       par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) par = ~par;
    head = {par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(head[i]);
    @(negedge clk);
    ps2_dat = bad_stop ? 1'b0 : 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    ps2_clk = 1'b0;
    model_frame(b, !bad_par && !bad_stop, cyc);
    repeat ($urandom_range(3, 8)) @(negedge clk);
    ps2_clk = 1'b1;
    repeat ($urandom_range(4, 20)) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    ev_t e;
    @(negedge clk);
    while (evq.size() > 0 && evq[evq.size()-1].due > cyc) void'(evq.pop_back());
    reset = 1'b1;
    e = blank_ev(cyc + 1);
    e.rst = 1;
    evq.push_back(e);
    m_key = 31; m_ext = 0; m_brk = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pool [21];
    int         kv_base;
    logic [7:0] b;
    int         r;

    plain_map[8'h1D] = 0;  plain_map[8'h1B] = 1;  plain_map[8'h1C] = 2;  plain_map[8'h23] = 3;
    plain_map[8'h43] = 8;  plain_map[8'h42] = 9;  plain_map[8'h3B] = 10; plain_map[8'h4B] = 11;
    plain_map[8'h75] = 12; plain_map[8'h73] = 13; plain_map[8'h6B] = 14; plain_map[8'h74] = 15;
    plain_map[8'h29] = 16;
    ext_map[8'h75] = 4; ext_map[8'h72] = 5; ext_map[8'h6B] = 6; ext_map[8'h74] = 7;

    repeat (3) @(negedge clk);
    check("reset key_pressed", 32'(key_pressed), 32'd31);
    check("reset key_valid",   32'(key_valid),   32'd0);
    check("reset scan_byte",   32'(scan_byte),   32'h00);
    check("reset frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    kv_base = kv_seen;
    good(8'h1D); settle();
    check("1D key", 32'(key_pressed), 32'd0);
    check("1D scan", 32'(scan_byte), 32'h1D);
    check("1D pulses", 32'(kv_seen - kv_base), 32'd1);

    good(8'hE0); good(8'h75); settle();
    check("E0 75 key", 32'(key_pressed), 32'd4);
    good(8'h75); settle();
    check("75 key", 32'(key_pressed), 32'd12);
    good(8'hE0); good(8'hF0); good(8'h75); settle();
    check("E0 F0 75 key", 32'(key_pressed), 32'd12);
    good(8'hF0); good(8'h75); settle();
    check("F0 75 key", 32'(key_pressed), 32'd31);

    send_frame(8'h23, 1'b1, 1'b0); settle();
    check("bad parity key", 32'(key_pressed), 32'd31);
    check("bad parity scan", 32'(scan_byte), 32'h75);
    good(8'h1C); settle();
    check("1C key", 32'(key_pressed), 32'd2);

    tmo_pulses = 0;
    m_ext = 0; m_brk = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    tmo_window = 1;
    repeat (5100) @(negedge clk);
    tmo_window = 0;
    check("timeout pulses", 32'(tmo_pulses), 32'd1);
    check("timeout key", 32'(key_pressed), 32'd2);
    good(8'h29); settle();
    check("29 key", 32'(key_pressed), 32'd16);

    kv_base = kv_seen;
    good(8'h1E); good(8'hF0); good(8'h1E); settle();
    check("unmapped key", 32'(key_pressed), 32'd16);
    check("unmapped pulses", 32'(kv_seen - kv_base), 32'd0);
    good(8'h43); good(8'h43); good(8'h43); settle();
    check("repeat pulses", 32'(kv_seen - kv_base), 32'd3);
    check("repeat key", 32'(key_pressed), 32'd8);

    good(8'hE0); good(8'hF0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    do_reset();
    check("mid-frame reset key", 32'(key_pressed), 32'd31);
    check("mid-frame reset scan", 32'(scan_byte), 32'h00);
    good(8'h42); settle();
    check("42 after reset", 32'(key_pressed), 32'd9);

    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h75, 8'h73,
             8'h6B, 8'h74, 8'h72, 8'h29, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h1E, 8'h00};
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 20));
      b = (r == 20) ? 8'($urandom) : pool[r];
      r = int'($urandom_range(0, 19));
      send_frame(b, r == 0, r == 1);
    end
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
